// File: rtl/button_event_queue.sv
// rtl/button_event_queue.sv - per-button sync, debounce, edge detect and event FIFO
module button_event_queue #(
  parameter int                N_BTN           = 5,
  parameter int                DEBOUNCE_CYCLES = 250000,
  parameter int                CNT_W           = 18,
  parameter int                FIFO_DEPTH      = 8,
  parameter logic [N_BTN-1:0]  IDLE_MASK       = 5'b10000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [2:0]       evt_id,
  output logic             evt_rise,
  output logic [3:0]       fifo_count,
  output logic             overflow,
  input  logic             overflow_clr
);

  localparam int         AW      = $clog2(FIFO_DEPTH);
  localparam logic [3:0] DEPTH_C = 4'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_BTN-1:0] s1, s2;
  logic [CNT_W-1:0] cnt [N_BTN];
  logic [N_BTN-1:0] commit, drop;
  logic [N_BTN-1:0] pv, prise;

  logic [3:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [3:0]    count;

  logic          push_any, push, pop;
  logic [2:0]    push_id;
  logic          push_rise;

  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      commit[i] = (s2[i] != btn_level[i]) && (cnt[i] == CNT_LAST);
      drop[i]   = commit[i] && pv[i];
    end
  end

  // Fixed priority: lowest channel index with a pending event wins.
  always_comb begin
    push_any  = 1'b0;
    push_id   = 3'd0;
    push_rise = 1'b0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (pv[i]) begin
        push_any  = 1'b1;
        push_id   = 3'(i);
        push_rise = prise[i];
      end
    end
  end

  assign evt_valid  = (count != 4'd0);
  assign pop        = evt_valid && evt_ready;
  assign push       = push_any && ((count < DEPTH_C) || pop);
  assign evt_id     = evt_valid ? mem[rd_ptr][3:1] : 3'd0;
  assign evt_rise   = evt_valid ? mem[rd_ptr][0]   : 1'b0;
  assign fifo_count = count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1        <= IDLE_MASK;
      s2        <= IDLE_MASK;
      btn_level <= IDLE_MASK;
      pv        <= '0;
      prise     <= '0;
      overflow  <= 1'b0;
      for (int i = 0; i < N_BTN; i++) cnt[i] <= '0;
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
      for (int i = 0; i < N_BTN; i++) begin
        if (s2[i] == btn_level[i]) begin
          cnt[i] <= '0;
        end else if (commit[i]) begin
          btn_level[i] <= s2[i];
          cnt[i]       <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
        // A held event is never overwritten; the newer edge is the one lost.
        if (commit[i] && !pv[i]) begin
          pv[i]    <= 1'b1;
          prise[i] <= s2[i];
        end else if (push && (push_id == 3'(i))) begin
          pv[i] <= 1'b0;
        end
      end
      if (|drop) overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {push_id, push_rise};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= 4'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: count <= count;
      endcase
    end
  end

endmodule
